// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S transmit path.
package i2s_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int HALF_BITS  = 17;
  localparam int FRAME_BITS = 2 * HALF_BITS;

  typedef enum logic [1:0] {
    SRC0_ONLY   = 2'd0,
    SRC1_ONLY   = 2'd1,
    PRIO0       = 2'd2,
    ROUND_ROBIN = 2'd3
  } src_mode_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_src_arbiter.sv
// Combinational choice of which stereo source is offered the next frame.
module i2s_src_arbiter
  import i2s_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);
  src_mode_t mode;
  assign mode = src_mode_t'(mode_i);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = 1'b0;
    case (mode)
      SRC0_ONLY: grant_valid_o = valid0_i;
      SRC1_ONLY: begin
        grant_valid_o = valid1_i;
        grant_idx_o   = 1'b1;
      end
      PRIO0: begin
        grant_valid_o = valid0_i | valid1_i;
        grant_idx_o   = ~valid0_i;
      end
      default: begin
        // Both ready: hand the frame to whoever did not get the last one.
        grant_valid_o = valid0_i | valid1_i;
        grant_idx_o   = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;
      end
    endcase
  end
endmodule

// File: rtl/i2s_tx_arbiter.sv
// I2S frame timing, per-frame source grant and MSB-first serializer.
module i2s_tx_arbiter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int HALF_BITS = 17,
  parameter int UNDER_W   = 8
) (
  input  logic                serial_clk,
  input  logic                reset,
  input  logic                src0_valid,
  input  logic [SAMPLE_W-1:0] src0_left,
  input  logic [SAMPLE_W-1:0] src0_right,
  output logic                src0_ready,
  input  logic                src1_valid,
  input  logic [SAMPLE_W-1:0] src1_left,
  input  logic [SAMPLE_W-1:0] src1_right,
  output logic                src1_ready,
  input  logic [1:0]          src_mode,
  input  logic                mute,
  output logic                word_select,
  output logic                sound_bit_out,
  output logic [5:0]          bit_counter,
  output logic                active_src,
  output logic [UNDER_W-1:0]  underrun_count,
  output logic                frame_start
);
  localparam int         FRAME_BITS = 2 * HALF_BITS;
  localparam int         IDX_W      = $clog2(SAMPLE_W);
  localparam logic [5:0] LOAD_SLOT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] WS_SLOT    = 6'(HALF_BITS - 1);
  localparam logic [5:0] L_END      = 6'(SAMPLE_W);
  localparam logic [5:0] R_FIRST    = 6'(HALF_BITS);
  localparam logic [5:0] R_END      = 6'(HALF_BITS + SAMPLE_W);

  logic [5:0]          cnt_q, cnt_d;
  logic                ws_q, sbit_q, sbit_d, act_q, last_q, mute_q, fs_q;
  logic [UNDER_W-1:0]  under_q;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic [IDX_W-1:0]    bidx;
  logic                load, gnt_vld, gnt_idx, xfer;

  assign load  = (cnt_q == LOAD_SLOT);
  assign cnt_d = load ? 6'd0 : cnt_q + 6'd1;

  i2s_src_arbiter u_arb (
    .mode_i        (src_mode),
    .valid0_i      (src0_valid),
    .valid1_i      (src1_valid),
    .last_grant_i  (last_q),
    .grant_valid_o (gnt_vld),
    .grant_idx_o   (gnt_idx)
  );

  // A grant always targets a valid source, so ready alone marks the transfer.
  assign xfer       = load & gnt_vld;
  assign src0_ready = xfer & ~gnt_idx;
  assign src1_ready = xfer & gnt_idx;

  always_comb begin
    sbit_d = 1'b0;
    bidx   = '0;
    if (cnt_q < L_END) begin
      bidx   = IDX_W'(L_END - 6'd1 - cnt_q);
      sbit_d = left_q[bidx];
    end else if (cnt_q >= R_FIRST && cnt_q < R_END) begin
      bidx   = IDX_W'(R_END - 6'd1 - cnt_q);
      sbit_d = right_q[bidx];
    end
    if (mute_q) sbit_d = 1'b0;
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      ws_q    <= 1'b0;
      sbit_q  <= 1'b0;
      act_q   <= 1'b0;
      last_q  <= 1'b1;
      mute_q  <= 1'b0;
      fs_q    <= 1'b0;
      under_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sbit_q <= sbit_d;
      fs_q   <= load;
      if (load)                 ws_q <= 1'b0;
      else if (cnt_q == WS_SLOT) ws_q <= 1'b1;
      if (load) begin
        if (xfer) begin
          left_q  <= gnt_idx ? src1_left  : src0_left;
          right_q <= gnt_idx ? src1_right : src0_right;
          act_q   <= gnt_idx;
          last_q  <= gnt_idx;
          mute_q  <= mute;
        end else begin
          left_q  <= '0;
          right_q <= '0;
          mute_q  <= 1'b0;
          if (under_q != '1) under_q <= under_q + UNDER_W'(1);
        end
      end
    end
  end

  assign bit_counter    = cnt_q;
  assign word_select    = ws_q;
  assign sound_bit_out  = sbit_q;
  assign active_src     = act_q;
  assign underrun_count = under_q;
  assign frame_start    = fs_q;
endmodule

// File: tb/tb_i2s_tx_arbiter.sv
// Scoreboard bench: expected frames are queued at each load and checked when serialized.
module tb_i2s_tx_arbiter;
  logic        serial_clk, reset;
  logic        src0_valid, src1_valid, src0_ready, src1_ready;
  logic [15:0] src0_left, src0_right, src1_left, src1_right;
  logic [1:0]  src_mode;
  logic        mute, word_select, sound_bit_out, active_src, frame_start;
  logic [5:0]  bit_counter;
  logic [7:0]  underrun_count;

  i2s_tx_arbiter dut (
    .serial_clk(serial_clk), .reset(reset),
    .src0_valid(src0_valid), .src0_left(src0_left), .src0_right(src0_right), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_left(src1_left), .src1_right(src1_right), .src1_ready(src1_ready),
    .src_mode(src_mode), .mute(mute), .word_select(word_select), .sound_bit_out(sound_bit_out),
    .bit_counter(bit_counter), .active_src(active_src), .underrun_count(underrun_count),
    .frame_start(frame_start)
  );

  initial serial_clk = 1'b0;
  always #5 serial_clk = ~serial_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // returns {grant_valid, grant_idx}
  function automatic logic [1:0] mgrant(input logic [1:0] md, input logic v0, input logic v1,
                                        input logic lst);
    case (md)
      2'd0:    return {v0, 1'b0};
      2'd1:    return {v1, 1'b1};
      2'd2:    return v0 ? 2'b10 : (v1 ? 2'b11 : 2'b00);
      default: begin
        if (v0 && v1) return {1'b1, ~lst};
        if (v0)       return 2'b10;
        if (v1)       return 2'b11;
        return 2'b00;
      end
    endcase
  endfunction

  typedef struct packed { logic [15:0] l; logic [15:0] r; logic s; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] lw, rw;
  logic [1:0]  g;
  logic        m_last, m_src, m_loaded;
  int          m_under, m_bc, bc;

  always @(negedge serial_clk) begin
    if (!reset) begin
      sb.delete();
      sb.push_back('{l: 16'h0, r: 16'h0, s: 1'b0});
      m_last = 1'b1; m_src = 1'b0; m_loaded = 1'b0;
      m_under = 0; m_bc = 1; lw = '0; rw = '0;
    end else begin
      bc = m_bc;
      chk("bit_counter", 32'(bit_counter), bc);
      chk("word_select", 32'(word_select), 32'(bc >= 17));
      chk("frame_start", 32'(frame_start), 32'(bc == 0 && m_loaded));
      if (bc >= 1 && bc <= 16) lw = {lw[14:0], sound_bit_out};
      if (bc >= 18)            rw = {rw[14:0], sound_bit_out};
      if (bc == 0 || bc == 17) chk("gap_bit", 32'(sound_bit_out), 0);
      if (bc == 2) chk("underrun", 32'(underrun_count), m_under);
      if (bc == 5 && sb.size() > 0) chk("active_src", 32'(active_src), 32'(sb[0].s));
      if (bc == 33) begin
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("left_word", 32'(lw), 32'(e.l));
          chk("right_word", 32'(rw), 32'(e.r));
        end
        g = mgrant(src_mode, src0_valid, src1_valid, m_last);
        chk("ready", 32'({src1_ready, src0_ready}), g[1] ? (g[0] ? 2 : 1) : 0);
        if (g[1]) begin
          e.s = g[0];
          e.l = mute ? 16'h0 : (g[0] ? src1_left : src0_left);
          e.r = mute ? 16'h0 : (g[0] ? src1_right : src0_right);
          m_last = g[0]; m_src = g[0];
        end else begin
          e = '{l: 16'h0, r: 16'h0, s: m_src};
          if (m_under != 255) m_under++;
        end
        sb.push_back(e);
        m_loaded = 1'b1;
        m_bc = 0;
      end else begin
        chk("ready_idle", 32'({src1_ready, src0_ready}), 0);
        m_bc = bc + 1;
      end
    end
  end

  task automatic to_slot(input int c);
    int n;
    n = 0;
    do begin
      @(negedge serial_clk);
      n++;
    end while (32'(bit_counter) != c && n < 100);
    chk("slot_reached", 32'(bit_counter), c);
    #1;
  endtask

  int u;

  initial begin
    reset = 1'b0; mute = 1'b0; src_mode = 2'd0;
    src0_valid = 1'b0; src1_valid = 1'b0;
    src0_left = '0; src0_right = '0; src1_left = '0; src1_right = '0;
    #2;
    chk("rst_bc", 32'(bit_counter), 0);
    chk("rst_ws", 32'(word_select), 0);
    chk("rst_under", 32'(underrun_count), 0);
    repeat (3) @(negedge serial_clk);
    #1 reset = 1'b1;

    // three empty frames
    to_slot(33); to_slot(33); to_slot(33);
    to_slot(2);
    chk("under_3", 32'(underrun_count), 3);

    // single source, known pattern
    to_slot(20);
    src0_valid = 1'b1; src0_left = 16'hA5F0; src0_right = 16'h0F0F;
    to_slot(33);
    to_slot(20); src0_valid = 1'b0;
    to_slot(33);

    // one src1 frame so round-robin starts from src0
    to_slot(20);
    src_mode = 2'd1; src1_valid = 1'b1; src1_left = 16'h3333; src1_right = 16'h4444;
    src0_valid = 1'b1; src0_left = 16'h1111; src0_right = 16'h2222;
    to_slot(33);
    to_slot(20); src_mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      to_slot(33);
      to_slot(5);
      chk("rr_src", 32'(active_src), i % 2);
    end

    // priority with src0 missing for one load
    to_slot(20); src_mode = 2'd2;
    to_slot(33);
    to_slot(20); src0_valid = 1'b0; u = underrun_count;
    to_slot(33);
    to_slot(1); src0_valid = 1'b1;
    to_slot(5);
    chk("prio_fallback", 32'(active_src), 1);
    chk("prio_under", 32'(underrun_count), u);
    to_slot(33);
    to_slot(5);
    chk("prio_back", 32'(active_src), 0);

    // mute consumes the sample but sends silence
    to_slot(20);
    src_mode = 2'd0; src1_valid = 1'b0; src0_left = 16'hFFFF; src0_right = 16'h1234;
    mute = 1'b1; u = underrun_count;
    to_slot(33);
    to_slot(1); mute = 1'b0;
    to_slot(5);
    chk("mute_under", 32'(underrun_count), u);
    to_slot(33);
    to_slot(33);

    // asynchronous reset in mid-frame
    to_slot(20); src_mode = 2'd1; src1_valid = 1'b1;
    to_slot(33);
    to_slot(20);
    reset = 1'b0;
    #1;
    chk("arst_bc", 32'(bit_counter), 0);
    chk("arst_ws", 32'(word_select), 0);
    chk("arst_sbit", 32'(sound_bit_out), 0);
    chk("arst_src", 32'(active_src), 0);
    chk("arst_under", 32'(underrun_count), 0);
    chk("arst_fs", 32'(frame_start), 0);
    chk("arst_ready", 32'({src1_ready, src0_ready}), 0);
    src_mode = 2'd0; src0_valid = 1'b1; src1_valid = 1'b0;
    repeat (3) @(negedge serial_clk);
    #1 reset = 1'b1;
    to_slot(33);
    to_slot(33);
    to_slot(1); src0_valid = 1'b0;

    // saturation
    for (int i = 0; i < 300; i++) to_slot(33);
    to_slot(2);
    chk("under_sat", 32'(underrun_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_tx_arbiter.md
Name: i2s_tx_arbiter

Overview:
- Frame controller and source arbiter for the I2S transmit path.
- Generates the I2S frame timing: bit counter, word_select and serial data.
- Once per frame, grants one of two stereo sample sources (e.g. DSP pipeline and test-tone generator) through a valid/ready handshake.
- Serializes the granted left and right samples MSB-first. Inserts silence and counts an underrun when no source can supply a sample.

Parameters:
- SAMPLE_W, 16, bits per channel sample.
- HALF_BITS, 17, bit slots per channel half-frame; must be > SAMPLE_W. Frame length FRAME_BITS = 2*HALF_BITS = 34.
- UNDER_W, 8, width of the saturating underrun counter.

Ports:
- serial_clk  in  1  bit clock.
- reset  in  1  reset, asynchronous, active-low.
- src0_valid  in  1  source 0 has a stereo sample.
- src0_left  in  SAMPLE_W  source 0 left sample.
- src0_right  in  SAMPLE_W  source 0 right sample.
- src0_ready  out  1  source 0 sample consumed this cycle (when valid).
- src1_valid, src1_left, src1_right, src1_ready: same as src0_* for source 1.
- src_mode  in  2  0 = src0 only, 1 = src1 only, 2 = fixed priority src0>src1, 3 = round-robin.
- mute  in  1  transmit silence; samples are still consumed.
- word_select  out  1  I2S WS; 0 = left, 1 = right.
- sound_bit_out  out  1  I2S serial data.
- bit_counter  out  6  current frame slot, 0..FRAME_BITS-1.
- active_src  out  1  source granted for the frame currently being serialized.
- underrun_count  out  UNDER_W  saturating count of frames with no grant.
- frame_start  out  1  one-cycle pulse while bit_counter == 0.

Behaviour:
- Reset values (immediate on reset low): bit_counter 0, word_select 0, sound_bit_out 0, active_src 0, underrun_count 0, frame_start 0, left/right holding registers 0, last_grant 1, mute_q 0.
- Counter: increments every serial_clk; wraps FRAME_BITS-1 -> 0.
- Load cycle: bit_counter == FRAME_BITS-1. src_mode, mute and the valids are sampled only here, so mid-frame changes take effect at the next frame.
- Grant (combinational, load cycle only):
  - mode 0: src0 if src0_valid.
  - mode 1: src1 if src1_valid.
  - mode 2: src0 if valid, else src1 if valid.
  - mode 3: if both valid, the source not equal to last_grant; if one valid, that source.
- srcN_ready = load cycle AND grant==N. Ready is never asserted outside the load cycle and never to both sources.
- Transfer = valid & ready. On transfer:
  - holding registers <= granted left/right.
  - active_src <= granted source; last_grant <= granted source.
  - mute_q <= mute.
- No transfer in the load cycle:
  - holding registers <= 0; mute_q <= 0.
  - underrun_count += 1, saturating at all-ones; active_src unchanged.
  - Mute does not count as underrun.
- Serialization (registered; a bit appears one cycle after its slot, giving the I2S one-bit delay after the WS edge). At an edge with bit_counter == c:
  - c < SAMPLE_W: sound_bit_out <= left[SAMPLE_W-1-c].
  - HALF_BITS <= c < HALF_BITS+SAMPLE_W: sound_bit_out <= right[SAMPLE_W-1-(c-HALF_BITS)].
  - otherwise: sound_bit_out <= 0.
  - mute_q forces sound_bit_out to 0.
- word_select: <= 1 at c == HALF_BITS-1; <= 0 at c == FRAME_BITS-1.
- frame_start: <= (c == FRAME_BITS-1).
- The frame following reset transmits silence. The first handshake occurs at the first load cycle after reset.
- Reset mid-frame aborts the frame with no partial handshake; counting restarts at slot 0.

Decomposition:
- Package i2s_pkg:
  - SAMPLE_W, HALF_BITS, FRAME_BITS localparams.
  - typedef enum src_mode_t {SRC0_ONLY, SRC1_ONLY, PRIO0, ROUND_ROBIN}.
  - typedef struct stereo_sample_t {left, right}.
- Sub-module i2s_src_arbiter: combinational grant from mode, valids and last_grant. Outputs grant_valid and grant_idx.
- Counter, holding registers and serializer stay in the top.

Test Plan:
- No valids, mode 0, 3 frames:
  - sound_bit_out stays 0.
  - word_select rises at the edge where bit_counter == 16 and falls where bit_counter == 33.
  - underrun_count reads 3.
  - Force 300 empty frames -> underrun_count holds at 255.
- mode 0, src0 valid, left = 16'hA5F0, right = 16'h0F0F:
  - src0_ready high only at bit_counter 33.
  - Next frame, sound_bit_out during bit_counter 1..16 = 1010010111110000, then 0 at 17.
  - During 18..33 = 0000111100001111.
- mode 3, both sources always valid:
  - Grants alternate 0,1,0,1 across four frames (active_src follows).
  - src0_ready and src1_ready are never high together.
- mode 2, src0_valid low for exactly one load cycle:
  - That frame src1 is granted and transmitted.
  - src0 is granted again at the following load cycle; underrun_count unchanged.
- mute = 1 at load with src0 valid (left = 16'hFFFF):
  - src0_ready pulses and the whole frame is 0.
  - underrun_count unchanged; with mute = 0 the next frame transmits normally.
- reset low while bit_counter == 20:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, counting restarts at 0; first ready at bit_counter 33; that frame is silent.
